cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the EX-stage ALU. It splits a WIDTH-bit operation into STAGES = WIDTH/SEG segments, one segment per clock. Each segment is built from 4-bit lookahead groups, and a registered carry passes between segments. Operands enter and results leave through valid/ready handshakes with full backpressure, a tag passes through alongside each operation, and a synchronous flush clears the pipeline on redirects. It returns a sum plus carry, overflow, zero and negative flags.

## Interface
- WIDTH, 32, operand/result width; a multiple of SEG
- SEG, 8, bits resolved per pipeline stage; a multiple of 4; STAGES = WIDTH/SEG, at least 1
- TAG_W, 5, width of the pass-through tag (e.g. destination register index)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  operation offered
- in_ready  out  1  adder can accept this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = subtract (A + ~B), 0 = add
- in_cin  in  1  extra carry/borrow input
- in_tag  in  TAG_W  passed through unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of the MSB (for subtraction, 1 = no borrow)
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0
- out_neg  out  1  out_sum[WIDTH-1]
- out_tag  out  TAG_W  tag of this result

## Operation
- Effective operand and carry-in:
  - b_eff = in_sub ? ~in_b : in_b
  - c0 = in_cin ^ in_sub
  - So sub with cin=0 gives A-B; sub with cin=1 gives A-B-1.
- Stage k (0..STAGES-1):
  - Computes sum bits [k*SEG +: SEG] combinationally.
  - Uses two-level lookahead over its SEG/4 groups.
  - Takes its carry-in from c0 (k=0) or from the carry registered by stage k-1.
- Stage register k holds:
  - valid_k
  - the sum bits resolved so far
  - A and b_eff bits not yet used
  - the running carry
  - a zero accumulator (AND of per-segment all-zero)
  - the tag
- The last stage additionally registers:
  - cout = carry out of bit WIDTH-1
  - ovf = carry into bit WIDTH-1 XOR cout
- Outputs are driven directly from register STAGES-1; out_valid = valid_{STAGES-1}.
- Advance rule:
  - Stage S-1 can load when !valid_{S-1} or (out_valid && out_ready).
  - Stage k < S-1 can load when !valid_k or stage k+1 can load.
  - in_ready = stage 0 can load. This is a combinational ready chain; no bubbles are inserted.
  - A register that cannot load holds its contents unchanged.
  - A register that loads takes the upstream contents, including valid = 0 bubbles.
- Result stability: while out_valid && !out_ready, all out_* hold their values bit-for-bit.
- flush:
  - Clears every valid_k at the next edge.
  - Overrides any acceptance in the same cycle, so that input is discarded even if in_ready=1.
  - Data registers need not clear.
- Ordering: results leave in acceptance order. There is no reordering and no loss.

## Timing
- Reset (rst_n low, asynchronous):
  - All valid_k = 0 and all data registers = 0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, out_neg=0, out_tag=0.
  - in_ready=1 as soon as rst_n is high.
- Reset mid-operation: in-flight operations are lost, and no result appears afterwards.
- Latency: a transfer in cycle n (in_valid && in_ready at that edge) produces out_valid in cycle n+STAGES, given the pipeline is not stalled.
- Throughput: one operation per cycle while out_ready=1.
- Full pipeline with out_ready=0: in_ready=0 in the same cycle. It returns to 1 in the cycle out_ready rises (pass-through ready).
- Wrap-around: sums are modulo 2^WIDTH. Carry out of the last segment goes to out_cout only.
- Simultaneous events:
  - With the pipeline full, out_ready=1 and in_valid=1 in the same cycle, the output and input transfers both occur and occupancy is unchanged.
  - flush and reset take precedence over both transfers.

## Test plan
- WIDTH=32, SEG=8 (STAGES=4) for all scenarios below.
- Carry across every segment: add 0xFFFFFFFF + 0x00000001, cin=0 -> sum 0x00000000, cout=1, zero=1, ovf=0, neg=0, out_valid exactly 4 cycles after the transfer. Then add 0x00FFFFFF + 0x00000001 -> 0x01000000, cout=0.
- Subtract/overflow:
  - 0x80000000 - 0x00000001 -> 0x7FFFFFFF, ovf=1, cout=1.
  - 0x00000003 - 0x00000005 -> 0xFFFFFFFE, cout=0, neg=1.
  - sub with cin=1: 10 - 3 -> 6.
- Streaming: 16 back-to-back random ops with out_ready=1 -> 16 consecutive out_valid cycles starting at cycle n+4. Every sum, flag and tag matches the reference model, in order.
- Backpressure: stream with out_ready=0 for 6 cycles -> in_ready falls after 4 accepts. Outputs stay stable. After release, all results appear in order with none lost or duplicated.
- Flush: flush asserted while 3 ops are in flight and in_valid=1 -> out_valid=0 from the next cycle, the same-cycle input is dropped, and the next accepted op returns correctly after 4 cycles.
- Reset mid-stream: rst_n pulsed low asynchronously with 2 ops in flight -> all outputs 0 immediately, and no stale result ever appears afterwards.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead add/sub for the EX-stage ALU.
// One SEG-bit slice per stage; registered carry chains the slices.
//
// Ports:
//   clk, rst_n (async low), flush (sync pipeline clear)
//   in_valid/in_ready/in_a/in_b/in_sub/in_cin/in_tag : operation input
//   out_valid/out_ready/out_sum/out_cout/out_ovf/out_zero/out_neg/out_tag
`timescale 1ns/1ps
module cla_pipe_adder #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             out_neg,
   output logic [TAG_W-1:0] out_tag
);

   localparam int STAGES = WIDTH / SEG;
   localparam int NG     = SEG / 4;

   // Returns {carry into MSB, carry out, sum} for one segment.
   // Group carries are flattened sum-of-products over the 4-bit groups.
   function automatic logic [SEG+1:0] seg_add(
      input logic [SEG-1:0] a,
      input logic [SEG-1:0] b,
      input logic           cin
   );
      logic [SEG-1:0] g;
      logic [SEG-1:0] p;
      logic [NG-1:0]  gg;
      logic [NG-1:0]  gp;
      logic [NG:0]    gc;
      logic [SEG:0]   c;
      logic           t;
      g = a & b;
      p = a ^ b;
      for (int j = 0; j < NG; j++) begin
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      for (int j = 0; j <= NG; j++) begin
         t = cin;
         for (int m = 0; m < j; m++) begin
            t = t & gp[m];
         end
         gc[j] = t;
         for (int i = 0; i < j; i++) begin
            t = gg[i];
            for (int m = i + 1; m < j; m++) begin
               t = t & gp[m];
            end
            gc[j] = gc[j] | t;
         end
      end
      c = '0;
      for (int j = 0; j < NG; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
         c[4*j+2] = g[4*j+1]
                  | (p[4*j+1] & g[4*j])
                  | (p[4*j+1] & p[4*j] & gc[j]);
         c[4*j+3] = g[4*j+2]
                  | (p[4*j+2] & g[4*j+1])
                  | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      end
      c[SEG] = gc[NG];
      return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
   endfunction

   logic             v_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic             c_q [STAGES];
   logic             z_q [STAGES];
   logic             o_q [STAGES];
   logic [TAG_W-1:0] t_q [STAGES];
   logic [STAGES-1:0] ld;
   logic [WIDTH-1:0] b_eff;

   assign b_eff = in_sub ? ~in_b : in_b;

   // Ready chain: a stage may load if empty or its successor moves.
   always_comb begin
      ld = '0;
      ld[STAGES-1] = !v_q[STAGES-1] | out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         ld[k] = !v_q[k] | ld[k+1];
      end
   end

   assign in_ready = ld[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             up_v;
      logic             up_c;
      logic             up_z;
      logic [WIDTH-1:0] up_s;
      logic [WIDTH-1:0] up_a;
      logic [WIDTH-1:0] up_b;
      logic [TAG_W-1:0] up_t;
      logic [WIDTH-1:0] nx_s;
      logic [SEG+1:0]   r;

      if (k == 0) begin : g_head
         assign up_v = in_valid;
         assign up_c = in_cin ^ in_sub;
         assign up_z = 1'b1;
         assign up_s = '0;
         assign up_a = in_a;
         assign up_b = b_eff;
         assign up_t = in_tag;
      end else begin : g_body
         assign up_v = v_q[k-1];
         assign up_c = c_q[k-1];
         assign up_z = z_q[k-1];
         assign up_s = s_q[k-1];
         assign up_a = a_q[k-1];
         assign up_b = b_q[k-1];
         assign up_t = t_q[k-1];
      end

      assign r = seg_add(up_a[k*SEG +: SEG],
                         up_b[k*SEG +: SEG], up_c);

      always_comb begin
         nx_s = up_s;
         nx_s[k*SEG +: SEG] = r[SEG-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q[k] <= 1'b0;
            s_q[k] <= '0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            c_q[k] <= 1'b0;
            z_q[k] <= 1'b0;
            o_q[k] <= 1'b0;
            t_q[k] <= '0;
         end else begin
            if (ld[k]) begin
               v_q[k] <= up_v;
               s_q[k] <= nx_s;
               a_q[k] <= up_a;
               b_q[k] <= up_b;
               c_q[k] <= r[SEG];
               z_q[k] <= up_z & (r[SEG-1:0] == '0);
               // Only meaningful in the last stage (MSB slice).
               o_q[k] <= r[SEG+1] ^ r[SEG];
               t_q[k] <= up_t;
            end
            if (flush) begin
               v_q[k] <= 1'b0;
            end
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign out_sum   = s_q[STAGES-1];
   assign out_cout  = c_q[STAGES-1];
   assign out_ovf   = o_q[STAGES-1];
   assign out_zero  = z_q[STAGES-1];
   assign out_neg   = s_q[STAGES-1][WIDTH-1];
   assign out_tag   = t_q[STAGES-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed table plus handshake sequences
// for the pipelined carry-lookahead adder.
`timescale 1ns/1ps
module tb_cla_pipe_adder;

   localparam int W  = 32;
   localparam int SG = 8;
   localparam int TW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_sub;
   logic          in_cin;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;
   logic          out_zero;
   logic          out_neg;
   logic [TW-1:0] out_tag;

   cla_pipe_adder #(.WIDTH(W), .SEG(SG), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
      .in_cin(in_cin), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout),
      .out_ovf(out_ovf), .out_zero(out_zero),
      .out_neg(out_neg), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        cin;
      logic [4:0]  tag;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
   } vec_t;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
      logic [4:0]  tag;
      int          cyc;
   } exp_t;

   int   pass_n = 0;
   int   total_n = 0;
   int   cyc = 0;
   int   nout = 0;
   bit   mon_en = 1'b0;
   bit   lat_chk = 1'b0;
   exp_t exp_q[$];
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] req);
      total_n++;
      if (act === req) pass_n++;
      else $display("FAIL %s: got %0h required %0h", nm, act, req);
   endtask

   function automatic exp_t model(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic sub, input logic cin,
                                  input logic [4:0] tag, input int c);
      logic [32:0] f;
      logic [31:0] be;
      exp_t        e;
      be = sub ? ~b : b;
      f = {1'b0, a} + {1'b0, be} + {32'b0, cin ^ sub};
      e.sum  = f[31:0];
      e.cout = f[32];
      e.ovf  = (a[31] == be[31]) && (f[31] != a[31]);
      e.zero = (f[31:0] == 32'h0);
      e.neg  = f[31];
      e.tag  = tag;
      e.cyc  = c;
      return e;
   endfunction

   // Scoreboard: push on accepted input, pop and compare on output.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         if (flush) begin
            exp_q.delete();
         end else begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("spurious_out", out_valid, 1'b0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("out_sum", out_sum, mon_e.sum);
                  check("out_flags",
                        {out_cout, out_ovf, out_zero, out_neg},
                        {mon_e.cout, mon_e.ovf, mon_e.zero, mon_e.neg});
                  check("out_tag", out_tag, mon_e.tag);
                  if (lat_chk) check("latency", cyc - mon_e.cyc, 4);
                  nout++;
               end
            end
            if (in_valid && in_ready)
               exp_q.push_back(model(in_a, in_b, in_sub, in_cin,
                                     in_tag, cyc));
         end
      end
   end

   // Holds the offered op until accepted; returns at posedge+1.
   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin,
                        input logic [4:0] tag);
      bit got;
      got = 1'b0;
      in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_tag = tag;
      in_valid = 1'b1;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
      end
      if (!got) check("drive_timeout", in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   vec_t        tbl[11];
   logic [31:0] bp_a[8];
   logic [31:0] bp_b[8];
   logic [41:0] snap;
   int          base;
   int          idx;
   int          lat;
   bit          acc;

   initial begin
      tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 5'd1,
                  32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 5'd2,
                  32'h01000000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 5'd3,
                  32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{32'h00000003, 32'h00000005, 1'b1, 1'b0, 5'd4,
                  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 5'd5,
                  32'h00000006, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 5'd6,
                  32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 5'd7,
                  32'h2345678A, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 5'd8,
                  32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 5'd31,
                  32'h0001FFFE, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 5'd0,
                  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 5'd9,
                  32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
      in_tag = '0; out_ready = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_sum", out_sum, 32'h0);
      check("rst_flags", {out_cout, out_ovf, out_zero, out_neg}, 4'h0);
      check("rst_out_tag", out_tag, 5'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Directed table: one op at a time, latency and result.
      for (int i = 0; i < 11; i++) begin
         in_a = tbl[i].a; in_b = tbl[i].b; in_sub = tbl[i].sub;
         in_cin = tbl[i].cin; in_tag = tbl[i].tag; in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat = 0;
         while (lat < 10 && !out_valid) begin
            @(negedge clk);
            lat++;
         end
         check($sformatf("tbl%0d_latency", i), lat, 4);
         check($sformatf("tbl%0d_sum", i), out_sum, tbl[i].sum);
         check($sformatf("tbl%0d_flags", i),
               {out_cout, out_ovf, out_zero, out_neg},
               {tbl[i].cout, tbl[i].ovf, tbl[i].zero, tbl[i].neg});
         check($sformatf("tbl%0d_tag", i), out_tag, tbl[i].tag);
         @(posedge clk);
         #1;
      end

      // Streaming: 16 back-to-back ops.
      mon_en = 1'b1; lat_chk = 1'b1; base = nout;
      for (int i = 0; i < 16; i++)
         drive($urandom, $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'(i));
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("stream_count", nout - base, 16);
      check("stream_q_empty", exp_q.size(), 0);

      // Backpressure: out_ready low for 6 cycles of offered input.
      lat_chk = 1'b0; base = nout; out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bp_a[i] = $urandom;
         bp_b[i] = $urandom;
      end
      idx = 0;
      in_a = bp_a[0]; in_b = bp_b[0]; in_sub = 1'b0; in_cin = 1'b0;
      in_tag = 5'd0; in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            in_a = bp_a[idx]; in_b = bp_b[idx];
            in_sub = idx[0]; in_tag = 5'(idx);
         end
      end
      @(negedge clk);
      check("bp_accepts", idx, 4);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      snap = {out_valid, out_sum, out_cout, out_ovf,
              out_zero, out_neg, out_tag};
      repeat (3) @(negedge clk);
      check("bp_stable", {out_valid, out_sum, out_cout, out_ovf,
                          out_zero, out_neg, out_tag}, snap);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_pass_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      idx++;
      while (idx < 8) begin
         drive(bp_a[idx], bp_b[idx], idx[0], 1'b0, 5'(idx));
         idx++;
      end
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("bp_count", nout - base, 8);
      check("bp_q_empty", exp_q.size(), 0);

      // Flush with 3 ops in flight and a same-cycle offer.
      lat_chk = 1'b1; base = nout;
      drive(32'h11111111, 32'h22222222, 1'b0, 1'b0, 5'd10);
      drive(32'h33333333, 32'h44444444, 1'b0, 1'b0, 5'd11);
      drive(32'h55555555, 32'h66666666, 1'b1, 1'b0, 5'd12);
      in_a = 32'hDEAD0000; in_b = 32'h0000BEEF; in_tag = 5'd13;
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("flush_out_valid", out_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      drive(32'h00001000, 32'h00000234, 1'b0, 1'b1, 5'd14);
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("flush_count", nout - base, 1);
      check("flush_q_empty", exp_q.size(), 0);

      // Reset with one result stalled and 2 ops in flight.
      out_ready = 1'b0;
      drive(32'h00000100, 32'h00000023, 1'b0, 1'b0, 5'd7);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_valid", out_valid, 1'b1);
      check("pre_rst_sum", out_sum, 32'h00000123);
      @(posedge clk);
      #1;
      drive(32'h00000001, 32'h00000002, 1'b0, 1'b0, 5'd20);
      drive(32'h00000003, 32'h00000004, 1'b0, 1'b0, 5'd21);
      in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_sum", out_sum, 32'h0);
      check("mid_rst_flags", {out_cout, out_ovf, out_zero, out_neg}, 4'h0);
      check("mid_rst_tag", out_tag, 5'h0);
      exp_q.delete();
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("post_rst_valid", out_valid, 1'b0);
      end
      check("post_rst_ready", in_ready, 1'b1);

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
